// File: rtl/vector_output_drain.sv
// vector_output_drain: buffers whole CPU output words in a small FIFO
// and drains them as a lane-by-lane byte stream with valid/ready.
//
// Ports:
//   clock, reset            single clock, async active-high reset
//   outFlag, out            one-cycle strobe qualifying a full output word
//   stallCPU                high while the word FIFO is full
//   byteData, byteValid     current lane of the head word, and its valid
//   byteReady               consumer accepts byteData this cycle
//   lastLane                byteValid on the final lane of a word
//   overflow                sticky, set when a word arrives while full
//   count                   words currently stored, 0..DEPTH
module vector_output_drain #(
  parameter int VECTOR_SIZE  = 6,
  parameter int OUTPUT_WIDTH = 8,
  parameter int DEPTH        = 4,
  parameter int PTR_WIDTH    = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                outFlag,
  input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] out,
  output logic                                stallCPU,
  output logic [OUTPUT_WIDTH-1:0]             byteData,
  output logic                                byteValid,
  input  logic                                byteReady,
  output logic                                lastLane,
  output logic                                overflow,
  output logic [PTR_WIDTH:0]                  count
);

  localparam int WORD_W = VECTOR_SIZE * OUTPUT_WIDTH;
  localparam int LANE_W =
    (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [PTR_WIDTH:0] FULL =
    (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_ONE =
    (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE =
    PTR_WIDTH'(1);
  localparam logic [LANE_W-1:0] LAST_LANE =
    LANE_W'(VECTOR_SIZE - 1);
  localparam logic [LANE_W-1:0] LANE_ONE =
    LANE_W'(1);

  logic [0:0]           state;
  logic [0:0]           state_next;
  logic [PTR_WIDTH-1:0] wrPtr;
  logic [PTR_WIDTH-1:0] rdPtr;
  logic [LANE_W-1:0]    lane;
  logic [WORD_W-1:0]    mem [DEPTH];
  logic [WORD_W-1:0]    head;
  logic [PTR_WIDTH:0]   count_next;

  logic full;
  logic push;
  logic drop;
  logic xfer;
  logic pop;
  logic on_last;

  // ---------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------
  assign full     = (count == FULL);
  assign push     = outFlag && !full;
  // A full FIFO drops the word even if a pop frees space this cycle.
  assign drop     = outFlag && full;
  assign byteValid = (state == SEND);
  assign xfer     = byteValid && byteReady;
  assign on_last  = (lane == LAST_LANE);
  assign pop      = xfer && on_last;

  assign stallCPU = full;
  assign lastLane = byteValid && on_last;

  // ---------------------------------------------------------------
  // Output lane select from the head word
  // ---------------------------------------------------------------
  assign head = mem[rdPtr];

  always_comb begin
    byteData = head[lane*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  end

  // ---------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // ---------------------------------------------------------------
  // Word storage; contents need no reset since count gates reads
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wrPtr] <= out;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
    end else if (push) begin
      wrPtr <= wrPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
    end else if (pop) begin
      rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------
  // Lane counter: advances on every accepted byte
  // ---------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane <= '0;
    end else if (xfer) begin
      if (on_last) begin
        lane <= '0;
      end else begin
        lane <= lane + LANE_ONE;
      end
    end
  end

  // ---------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = SEND;
        end
      end
      SEND: begin
        // Stay put across word boundaries when more words wait,
        // including one pushed in this same cycle.
        if (pop && (count_next == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------
  // Sticky drop flag
  // ---------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_output_drain.sv
// Scoreboard bench for vector_output_drain: directed words, expected
// bytes queued at issue time, negedge monitor pops and compares.
module tb_vector_output_drain;

  localparam int VS = 6;
  localparam int OW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          outFlag = 1'b0;
  logic [VS*OW-1:0] out = '0;
  logic          stallCPU;
  logic [OW-1:0] byteData;
  logic          byteValid;
  logic          byteReady = 1'b0;
  logic          lastLane;
  logic          overflow;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];

  vector_output_drain dut (
    .clock    (clock),
    .reset    (reset),
    .outFlag  (outFlag),
    .out      (out),
    .stallCPU (stallCPU),
    .byteData (byteData),
    .byteValid(byteValid),
    .byteReady(byteReady),
    .lastLane (lastLane),
    .overflow (overflow),
    .count    (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one outFlag cycle; queues bytes unless a drop is expected.
  task automatic push_word(input logic [VS*OW-1:0] w,
                           input bit dropped);
    outFlag = 1'b1;
    out = w;
    if (!dropped) begin
      for (int k = 0; k < VS; k++) begin
        sb.push_back({(k == VS-1), w[k*OW +: OW]});
      end
    end
    tick();
    outFlag = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(count == 0 && !byteValid)) begin
      tick();
      n++;
    end
    chk("drain_done", {31'd0, (count == 0 && !byteValid)}, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Monitor: every accepted byte must match the queue head.
  always @(negedge clock) begin
    if (!reset && byteValid && byteReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte got %0h expected none",
                 byteData);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("byte_data", {24'd0, byteData}, {24'd0, e[7:0]});
        chk("last_lane", {31'd0, lastLane}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", {31'd0, byteValid}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_stall", {31'd0, stallCPU}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_last", {31'd0, lastLane}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single word, latency
    byteReady = 1'b1;
    push_word(48'h65_54_43_32_21_10, 0);
    chk("t1_c1_count", {29'd0, count}, 1);
    chk("t1_c1_valid", {31'd0, byteValid}, 0);
    tick();
    chk("t1_c2_valid", {31'd0, byteValid}, 1);
    chk("t1_c2_data", {24'd0, byteData}, 32'h10);
    repeat (6) tick();
    chk("t1_c8_valid", {31'd0, byteValid}, 0);
    chk("t1_c8_count", {29'd0, count}, 0);
    chk("t1_sb", sb.size(), 0);

    // Backpressure in cycles 3..5
    push_word(48'h65_54_43_32_21_10, 0);
    tick();
    tick();
    byteReady = 1'b0;
    chk("t2_c3_data", {24'd0, byteData}, 32'h21);
    tick();
    tick();
    chk("t2_c5_data", {24'd0, byteData}, 32'h21);
    chk("t2_c5_valid", {31'd0, byteValid}, 1);
    tick();
    byteReady = 1'b1;
    chk("t2_c6_data", {24'd0, byteData}, 32'h21);
    repeat (4) tick();
    chk("t2_c10_last", {31'd0, lastLane}, 1);
    chk("t2_c10_data", {24'd0, byteData}, 32'h65);
    tick();
    chk("t2_c11_valid", {31'd0, byteValid}, 0);

    // Fill and overflow
    byteReady = 1'b0;
    push_word(48'hA5_A4_A3_A2_A1_A0, 0);
    push_word(48'hB5_B4_B3_B2_B1_B0, 0);
    chk("t3_c2_stall", {31'd0, stallCPU}, 0);
    push_word(48'hC5_C4_C3_C2_C1_C0, 0);
    chk("t3_c3_stall", {31'd0, stallCPU}, 0);
    push_word(48'hD5_D4_D3_D2_D1_D0, 0);
    chk("t3_c4_stall", {31'd0, stallCPU}, 1);
    chk("t3_c4_count", {29'd0, count}, 4);
    chk("t3_c4_ovf", {31'd0, overflow}, 0);
    push_word(48'hE5_E4_E3_E2_E1_E0, 1);
    chk("t3_c5_ovf", {31'd0, overflow}, 1);
    chk("t3_c5_count", {29'd0, count}, 4);
    byteReady = 1'b1;
    repeat (5) tick();
    chk("t3_c10_stall", {31'd0, stallCPU}, 1);
    tick();
    chk("t3_c11_stall", {31'd0, stallCPU}, 0);
    chk("t3_c11_count", {29'd0, count}, 3);
    wait_idle(40);
    chk("t3_ovf_sticky", {31'd0, overflow}, 1);
    do_reset();
    chk("t3_ovf_clr", {31'd0, overflow}, 0);

    // Push coinciding with a lane-5 pop
    byteReady = 1'b1;
    push_word(48'h1F_1E_1D_1C_1B_1A, 0);
    push_word(48'h2F_2E_2D_2C_2B_2A, 0);
    repeat (5) tick();
    chk("t4_c7_count", {29'd0, count}, 2);
    chk("t4_c7_last", {31'd0, lastLane}, 1);
    push_word(48'h3F_3E_3D_3C_3B_3A, 0);
    chk("t4_c8_count", {29'd0, count}, 2);
    chk("t4_c8_valid", {31'd0, byteValid}, 1);
    chk("t4_c8_data", {24'd0, byteData}, 32'h2A);
    wait_idle(30);

    // Pointer wrap: 10 words one at a time
    for (int i = 0; i < 10; i++) begin
      logic [VS*OW-1:0] w;
      for (int k = 0; k < VS; k++) begin
        w[k*OW +: OW] = 8'(i * 16 + k + 3);
      end
      push_word(w, 0);
      wait_idle(20);
    end

    // Reset mid-burst at lane 3
    push_word(48'h75_74_73_72_71_70, 0);
    push_word(48'h85_84_83_82_81_80, 0);
    push_word(48'h95_94_93_92_91_90, 0);
    tick();
    tick();
    chk("t6_c5_data", {24'd0, byteData}, 32'h73);
    chk("t6_c5_count", {29'd0, count}, 3);
    #1 reset = 1'b1;
    #1;
    sb.delete();
    chk("t6_valid", {31'd0, byteValid}, 0);
    chk("t6_count", {29'd0, count}, 0);
    chk("t6_stall", {31'd0, stallCPU}, 0);
    chk("t6_ovf", {31'd0, overflow}, 0);
    chk("t6_last", {31'd0, lastLane}, 0);
    tick();
    reset = 1'b0;
    tick();
    push_word(48'hC6_C5_C4_C3_C2_C1, 0);
    tick();
    chk("t6_new_data", {24'd0, byteData}, 32'hC1);
    wait_idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_output_drain.md
# vector_output_drain

Buffers vector results the CPU emits on its output port (one `outFlag` pulse carries all `VECTOR_SIZE` lanes) and drains them to a host as a lane-by-lane byte stream with a valid/ready handshake. It sits between `CPU`'s `out`/`outFlag` and the off-chip or bench consumer. It throttles the pipeline with `stallCPU` when its word FIFO is full, and records any dropped word in a sticky `overflow` flag.

## Interface
- `VECTOR_SIZE`, 6, lanes per output word
- `OUTPUT_WIDTH`, 8, bits per lane
- `DEPTH`, 4, FIFO depth in words; must be a power of two, at least 2
- `PTR_WIDTH`, 2, log2(`DEPTH`)
- `clock`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `outFlag`  in  1  high for one cycle per output word; qualifies `out`
- `out`  in  `VECTOR_SIZE*OUTPUT_WIDTH`  output word; lane k is `out[k*OUTPUT_WIDTH +: OUTPUT_WIDTH]`
- `stallCPU`  out  1  high while the FIFO holds `DEPTH` words
- `byteData`  out  `OUTPUT_WIDTH`  current lane of the head word
- `byteValid`  out  1  `byteData` is valid
- `byteReady`  in  1  consumer accepts `byteData` this cycle
- `lastLane`  out  1  high with `byteValid` when the lane index is `VECTOR_SIZE-1`
- `overflow`  out  1  sticky; set when a word is dropped
- `count`  out  `PTR_WIDTH+1`  words currently stored, 0..`DEPTH`

## Operation
- Storage is a circular FIFO with `wrPtr` and `rdPtr` (each `PTR_WIDTH` bits, wrapping at `DEPTH`) and a `count` register.
- Push: `outFlag` high and `count<DEPTH` writes `out` at `wrPtr`; `wrPtr` increments.
- Full case: `outFlag` high and `count==DEPTH` drops the word and sets `overflow`. The word is dropped even if a pop happens in the same cycle.
- FSM states:
  - IDLE: `byteValid=0`. Goes to SEND at the edge where `count!=0`, with `lane=0`.
  - SEND: `byteValid=1`. `byteData` is lane `lane` of the word at `rdPtr`.
- Handshake, a transfer is `byteValid && byteReady`:
  - Transfer with `lane<VECTOR_SIZE-1`: `lane` increments.
  - Transfer with `lane==VECTOR_SIZE-1`: pop (`rdPtr` increments), and `lane` returns to 0. The FSM stays in SEND if the FIFO is still non-empty after the push/pop of this cycle; otherwise it goes to IDLE.
- Lane order is 0 first (LSBs) through `VECTOR_SIZE-1`.
- `count` rules:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle (only possible when `count<DEPTH` before the edge): unchanged.
- `stallCPU = (count==DEPTH)`, combinational from the `count` register.
- `lastLane = byteValid && (lane==VECTOR_SIZE-1)`.
- `overflow` is cleared only by `reset`.

## Timing
- Reset values:
  - `count=0`, `wrPtr=rdPtr=0`, `lane=0`, state IDLE.
  - `byteValid=0`, `lastLane=0`, `stallCPU=0`, `overflow=0`.
  - `byteData`: contents of FIFO entry 0, lane 0. Don't-care while `byteValid=0`.
- Reset is asynchronous: asserting it mid-burst drops `byteValid` and clears the FIFO without waiting for a clock edge. Partially sent words are discarded.
- Latency, with the FIFO empty and the FSM in IDLE:
  - `outFlag` in cycle 0 → push at the end of cycle 0.
  - `count=1` in cycle 1; IDLE→SEND at the end of cycle 1.
  - First `byteValid` in cycle 2.
- Throughput: with `byteReady` held high, 1 byte per cycle and `VECTOR_SIZE` cycles per word. There is no bubble between consecutive words when the next word is already stored.
- Backpressure: while `byteValid && !byteReady`, `byteData`, `lane` and `rdPtr` stay stable.
- `stallCPU` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the pop that frees an entry.

## Test plan
- Single word: reset, then `outFlag=1` with lanes 0..5 = 0x10,0x21,0x32,0x43,0x54,0x65 and `byteReady=1` → `byteValid` in cycles 2..7 with bytes 0x10..0x65 in order. `lastLane` only with 0x65; `count` returns to 0; IDLE in cycle 8.
- Backpressure: same word, `byteReady` low in cycles 3–5 → 0x21 is held for 4 cycles, no byte is lost or duplicated, and the last byte arrives in cycle 10.
- Fill and overflow: `byteReady=0`, 5 consecutive `outFlag` words A..E → `count=4`, `stallCPU=1` from the cycle after D's push, word E dropped, `overflow=1`. Then release `byteReady` → A..D drained in order, `overflow` still 1.
- Simultaneous push/pop: `count=2`, and `outFlag` arrives in the cycle of a lane-5 transfer → `count` stays 2, the new word comes after the existing one, and there is no gap between words.
- Pointer wrap: push and drain 10 distinct words one at a time → every word is received intact, with the pointers wrapped twice.
- Reset mid-burst: assert `reset` in the lane-3 cycle of a word with 2 more stored → `byteValid`, `count`, `stallCPU` and `overflow` go to 0 before the next edge. A new word after release is received from lane 0.
